t30_stack_node: RTL and testbench
=================================

Name: t30_stack_node

Overview:
- TIS-100 T30 stack memory node. It tiles into the node grid next to t21_node and connects to it through the same four directional 11-bit channels.
- Any neighbour can push words into it and pop them back out in LIFO order.
- It has no program. It is a passive store that arbitrates its four ports and replaces an empty grid slot, so compute nodes can spill values into it.

Parameters:
- WIDTH, 11, data word width in bits (signed, -999..999 range carried unchanged)
- DEPTH, 15, stack capacity in words
- CNT_W, 4, count register width; must satisfy 2**CNT_W > DEPTH

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- left_in_data / right_in_data / up_in_data / down_in_data  in  WIDTH each  word offered by that neighbour for push
- left_in_ready / right_in_ready / up_in_ready / down_in_ready  in  1 each  neighbour is offering a word
- left_in_ack / right_in_ack / up_in_ack / down_in_ack  out  1 each  one-cycle pulse: offered word was pushed
- left_out_req / right_out_req / up_out_req / down_out_req  in  1 each  neighbour wants to pop a word
- left_out_data / right_out_data / up_out_data / down_out_data  out  WIDTH each  popped word
- left_out_ready / right_out_ready / up_out_ready / down_out_ready  out  1 each  one-cycle pulse: out_data is valid, word popped
- count  out  CNT_W  current number of stored words (debug/visibility)

Behaviour:
- Reset (reset=0, async):
  - count=0; every *_in_ack=0; every *_out_ready=0; every *_out_data=0.
  - Storage contents are don't-care.
  - Any transfer in flight is dropped, with no ack and no ready.
- Storage: DEPTH x WIDTH register array indexed by count. Top of stack = entry[count-1].
- All outputs are registered. Each response appears on the cycle after the request is sampled.
- Push arbitration, per rising edge:
  - A direction is eligible when its in_ready=1 and its in_ack is currently 0.
  - Masking by in_ack prevents a double push while the neighbour drops in_ready.
  - Fixed priority: left > right > up > down.
  - At most one push per cycle.
- Pop arbitration, per rising edge:
  - A direction is eligible when its out_req=1 and its out_ready is currently 0.
  - Same fixed priority, left > right > up > down.
  - At most one pop per cycle.
- Edge actions (P = push winner exists, Q = pop winner exists):
  - Q and count>0: winner's out_data<=entry[count-1]; winner's out_ready<=1 for one cycle.
  - P, and (count<DEPTH or a pop is granted this edge): store word; winner's in_ack<=1 for one cycle.
  - Push and pop on the same edge: the pop returns the old top, the pushed word replaces it, count is unchanged.
  - Push only: entry[count]<=data; count+1.
  - Pop only: count-1.
- Push with count=DEPTH and no pop: rejected, no ack. The neighbour keeps in_ready high and retries each cycle.
- Pop with count=0: no response, even if a push is granted the same edge. The requester stays pending; it is served from the next cycle once count>0. Empty stacks never return data.
- Losing requesters get nothing that cycle and win later by priority. Starvation of a low-priority port under continuous high-priority traffic is accepted.
- Non-winning out_data ports hold their last value. Only the ready pulse qualifies the data.
- count never exceeds DEPTH and never wraps below 0.
- Neighbour contract:
  - Drop in_ready, or present new data, on the cycle after sampling in_ack=1.
  - Drop out_req on the cycle after sampling out_ready=1.
  - Data must be stable while in_ready is high.

Test Plan:
- Reset then LIFO:
  - Push 5, -7, 999 from left, each push acked one cycle after in_ready.
  - Pop three times from up.
  - Required: up_out_data = 999, -7, 5 with up_out_ready pulses; count 3->0.
- Full boundary:
  - Push 15 words (1..15) from right; count=15.
  - A 16th in_ready stays high 10 cycles with no right_in_ack.
  - A single down pop returns 15; the 16th word is acked the same edge; count stays 15.
- Push and pop on the same edge:
  - With count=2 and top=4, left pushes 8 while up requests in the same cycle.
  - Required: up gets 4, left gets ack, count=2, top=8.
- Priority:
  - left and down assert in_ready together with 1 and 2, stack empty.
  - Required: left acked first, down next cycle; a subsequent pop returns 2.
- Empty pop:
  - right_out_req held with count=0 for 5 cycles: no right_out_ready.
  - Then up pushes 42: right_out_ready with data 42 one cycle after the push edge; count back to 0.
- Reset mid-operation:
  - Assert reset while count=6 and left_in_ready is high.
  - Required: all acks/readies 0 and count=0 immediately.
  - After release, a pop request gets no response until a new push.

Source files
------------

// File: rtl/t30_stack_node.sv
// t30_stack_node
// ----------------------------------------------------------------------------
// Passive LIFO memory node for the TIS-100 style node grid. Any of the four
// neighbours may push a word into it or pop the most recent word back out.
// Each edge grants at most one push and at most one pop. When several
// directions request at once, left wins over right, right over up, and up
// over down. All responses are registered and appear one cycle after the
// request is sampled.
//
// Ports
//   clk                 rising-edge system clock
//   reset               asynchronous, active-low reset
//   <dir>_in_data       word offered for push by that neighbour
//   <dir>_in_ready      neighbour is offering a word
//   <dir>_in_ack        one-cycle pulse: offered word was pushed
//   <dir>_out_req       neighbour wants to pop a word
//   <dir>_out_data      last word popped towards that neighbour
//   <dir>_out_ready     one-cycle pulse: out_data is valid, word popped
//   count               number of words currently stored
//   (<dir> is one of left, right, up, down)
// ----------------------------------------------------------------------------
module t30_stack_node #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 15,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] left_in_data,
    input  logic [WIDTH-1:0] right_in_data,
    input  logic [WIDTH-1:0] up_in_data,
    input  logic [WIDTH-1:0] down_in_data,
    input  logic             left_in_ready,
    input  logic             right_in_ready,
    input  logic             up_in_ready,
    input  logic             down_in_ready,
    output logic             left_in_ack,
    output logic             right_in_ack,
    output logic             up_in_ack,
    output logic             down_in_ack,
    input  logic             left_out_req,
    input  logic             right_out_req,
    input  logic             up_out_req,
    input  logic             down_out_req,
    output logic [WIDTH-1:0] left_out_data,
    output logic [WIDTH-1:0] right_out_data,
    output logic [WIDTH-1:0] up_out_data,
    output logic [WIDTH-1:0] down_out_data,
    output logic             left_out_ready,
    output logic             right_out_ready,
    output logic             up_out_ready,
    output logic             down_out_ready,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Direction index: 0 = left, 1 = right, 2 = up, 3 = down.
    // The lowest index has the highest priority.
    logic [3:0]       in_ready_v;
    logic [3:0]       out_req_v;
    logic [WIDTH-1:0] in_data_a [4];

    logic [3:0]       ack_q;
    logic [3:0]       rdy_q;
    logic [WIDTH-1:0] out_data_q [4];
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [3:0]       push_elig, pop_elig;
    logic [3:0]       push_win, pop_win;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] push_data;
    logic [CNT_W-1:0] top_idx;
    logic [CNT_W-1:0] wr_idx;

    assign in_ready_v = {down_in_ready, up_in_ready, right_in_ready, left_in_ready};
    assign out_req_v  = {down_out_req, up_out_req, right_out_req, left_out_req};
    assign in_data_a[0] = left_in_data;
    assign in_data_a[1] = right_in_data;
    assign in_data_a[2] = up_in_data;
    assign in_data_a[3] = down_in_data;

    // A direction whose ack/ready pulse is currently high is masked off.
    // This prevents a second grant on the cycle the neighbour is still
    // retracting its request.
    assign push_elig = in_ready_v & ~ack_q;
    assign pop_elig  = out_req_v & ~rdy_q;

    // Isolate the lowest set bit (x & -x), which is the highest-priority
    // requester.
    assign push_win = push_elig & (~push_elig + 4'd1);
    assign pop_win  = pop_elig & (~pop_elig + 4'd1);

    // An empty stack never answers a pop, even when a push lands on the
    // same edge. A full stack still takes a push if a pop frees the top slot.
    assign pop_ok  = (|pop_win) && (count_q != '0);
    assign push_ok = (|push_win) && ((count_q != DEPTH_C) || pop_ok);

    assign top_idx = count_q - CNT_W'(1);
    // On a simultaneous push and pop, the new word overwrites the old top.
    assign wr_idx  = pop_ok ? top_idx : count_q;

    always_comb begin
        push_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (push_win[i]) begin
                push_data = in_data_a[i];
            end
        end
    end

    // Handshake pulses, popped data and the fill level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q   <= '0;
            rdy_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < 4; i++) begin
                out_data_q[i] <= '0;
            end
        end else begin
            ack_q <= push_ok ? push_win : 4'd0;
            rdy_q <= pop_ok ? pop_win : 4'd0;
            for (int i = 0; i < 4; i++) begin
                if (pop_ok && pop_win[i]) begin
                    out_data_q[i] <= mem[top_idx];
                end
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage has no reset; its contents only matter below count.
    always_ff @(posedge clk) begin
        if (push_ok && reset) begin
            mem[wr_idx] <= push_data;
        end
    end

    assign left_in_ack     = ack_q[0];
    assign right_in_ack    = ack_q[1];
    assign up_in_ack       = ack_q[2];
    assign down_in_ack     = ack_q[3];
    assign left_out_ready  = rdy_q[0];
    assign right_out_ready = rdy_q[1];
    assign up_out_ready    = rdy_q[2];
    assign down_out_ready  = rdy_q[3];
    assign left_out_data   = out_data_q[0];
    assign right_out_data  = out_data_q[1];
    assign up_out_data     = out_data_q[2];
    assign down_out_data   = out_data_q[3];
    assign count           = count_q;

endmodule

// File: tb/tb_t30_stack_node.sv
// tb_t30_stack_node
// ----------------------------------------------------------------------------
// Self-checking bench for t30_stack_node.
//
// A table of per-cycle vectors covers:
//   - LIFO ordering
//   - push priority
//   - a push and a pop on the same edge
//
// Hand-written sequences cover:
//   - the full boundary
//   - a pop from an empty stack
//   - reset in the middle of operation
//
// Expected pop results go into a scoreboard queue when the request is driven.
// They are taken out and compared whenever an out_ready pulse is seen.
// ----------------------------------------------------------------------------
module tb_t30_stack_node;

    localparam int WIDTH = 11;
    localparam int DEPTH = 15;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data [4];
    logic [3:0]       in_ready;
    logic [3:0]       out_req;
    wire  [3:0]       in_ack;
    wire  [3:0]       out_ready;
    wire  [WIDTH-1:0] out_data [4];
    wire  [CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int               dir;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    typedef struct {
        logic [3:0]            push;
        logic [3:0][WIDTH-1:0] pdata;
        logic [3:0]            pop;
        logic [3:0]            exp_ack;
        logic [3:0]            exp_rdy;
        int                    exp_cnt;
        logic [WIDTH-1:0]      exp_data;
    } vec_t;

    vec_t vecs [40];
    int   n_vecs = 0;

    t30_stack_node #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .left_in_data    (in_data[0]),
        .right_in_data   (in_data[1]),
        .up_in_data      (in_data[2]),
        .down_in_data    (in_data[3]),
        .left_in_ready   (in_ready[0]),
        .right_in_ready  (in_ready[1]),
        .up_in_ready     (in_ready[2]),
        .down_in_ready   (in_ready[3]),
        .left_in_ack     (in_ack[0]),
        .right_in_ack    (in_ack[1]),
        .up_in_ack       (in_ack[2]),
        .down_in_ack     (in_ack[3]),
        .left_out_req    (out_req[0]),
        .right_out_req   (out_req[1]),
        .up_out_req      (out_req[2]),
        .down_out_req    (out_req[3]),
        .left_out_data   (out_data[0]),
        .right_out_data  (out_data[1]),
        .up_out_data     (out_data[2]),
        .down_out_data   (out_data[3]),
        .left_out_ready  (out_ready[0]),
        .right_out_ready (out_ready[1]),
        .up_out_ready    (out_ready[2]),
        .down_out_ready  (out_ready[3]),
        .count           (count)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [WIDTH-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_expect(input int dir, input int data);
        exp_t e;
        e.dir  = dir;
        e.data = WIDTH'(data);
        sb_q.push_back(e);
    endtask

    // d is offered on left/right/up and dd on down, so that the priority
    // vector can tell which word was stored.
    task automatic add_vec(input logic [3:0] push, input int d, input int dd,
                           input logic [3:0] pop, input logic [3:0] ack,
                           input logic [3:0] rdy, input int cnt, input int e);
        vec_t v;
        v.push     = push;
        v.pdata[0] = WIDTH'(d);
        v.pdata[1] = WIDTH'(d);
        v.pdata[2] = WIDTH'(d);
        v.pdata[3] = WIDTH'(dd);
        v.pop      = pop;
        v.exp_ack  = ack;
        v.exp_rdy  = rdy;
        v.exp_cnt  = cnt;
        v.exp_data = WIDTH'(e);
        vecs[n_vecs] = v;
        n_vecs++;
    endtask

    task automatic apply_stimulus(input vec_t v);
        in_ready = v.push;
        out_req  = v.pop;
        for (int i = 0; i < 4; i++) begin
            if (v.push[i]) in_data[i] = v.pdata[i];
            if (v.exp_rdy[i]) sb_expect(i, sx(v.exp_data));
        end
    endtask

    task automatic check_output(input vec_t v, input int k);
        check($sformatf("v%0d_ack", k), int'(in_ack), int'(v.exp_ack));
        check($sformatf("v%0d_ready", k), int'(out_ready), int'(v.exp_rdy));
        check($sformatf("v%0d_count", k), int'(count), v.exp_cnt);
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                if (out_ready[i]) begin
                    check($sformatf("sb_pending_dir%0d", i), int'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        mon_e = sb_q.pop_front();
                        check("sb_dir", i, mon_e.dir);
                        check("sb_data", sx(out_data[i]), sx(mon_e.data));
                    end
                end
            end
        end
    end

    initial begin
        reset    = 1'b0;
        in_ready = '0;
        out_req  = '0;
        for (int i = 0; i < 4; i++) in_data[i] = '0;

        #2;
        check("rst_count", int'(count), 0);
        check("rst_ack", int'(in_ack), 0);
        check("rst_ready", int'(out_ready), 0);
        for (int i = 0; i < 4; i++) check($sformatf("rst_data%0d", i), sx(out_data[i]), 0);

        repeat (2) tick();
        reset = 1'b1;
        tick();

        // LIFO: push 5, -7, 999 from left, then pop three times from up.
        add_vec(4'b0001,   5, 0, 4'b0000, 4'b0001, 4'b0000, 1,   0);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 1,   0);
        add_vec(4'b0001,  -7, 0, 4'b0000, 4'b0001, 4'b0000, 2,   0);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 2,   0);
        add_vec(4'b0001, 999, 0, 4'b0000, 4'b0001, 4'b0000, 3,   0);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 3,   0);
        add_vec(4'b0000,   0, 0, 4'b0100, 4'b0000, 4'b0100, 2, 999);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 2,   0);
        add_vec(4'b0000,   0, 0, 4'b0100, 4'b0000, 4'b0100, 1,  -7);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 1,   0);
        add_vec(4'b0000,   0, 0, 4'b0100, 4'b0000, 4'b0100, 0,   5);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 0,   0);
        // Priority: left(1) and down(2) together on an empty stack.
        add_vec(4'b1001,   1, 2, 4'b0000, 4'b0001, 4'b0000, 1,   0);
        add_vec(4'b1000,   1, 2, 4'b0000, 4'b1000, 4'b0000, 2,   0);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 2,   0);
        add_vec(4'b0000,   0, 0, 4'b0001, 4'b0000, 4'b0001, 1,   2);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 1,   0);
        add_vec(4'b0000,   0, 0, 4'b0001, 4'b0000, 4'b0001, 0,   1);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 0,   0);
        // Same-edge push and pop: stack {3,4}, left pushes 8 while up pops.
        add_vec(4'b0010,   3, 0, 4'b0000, 4'b0010, 4'b0000, 1,   0);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 1,   0);
        add_vec(4'b0010,   4, 0, 4'b0000, 4'b0010, 4'b0000, 2,   0);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 2,   0);
        add_vec(4'b0001,   8, 0, 4'b0100, 4'b0001, 4'b0100, 2,   4);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 2,   0);
        add_vec(4'b0000,   0, 0, 4'b0100, 4'b0000, 4'b0100, 1,   8);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 1,   0);
        add_vec(4'b0000,   0, 0, 4'b0100, 4'b0000, 4'b0100, 0,   3);
        add_vec(4'b0000,   0, 0, 4'b0000, 4'b0000, 4'b0000, 0,   0);

        for (int k = 0; k < n_vecs; k++) begin
            apply_stimulus(vecs[k]);
            tick();
            check_output(vecs[k], k);
        end

        // Full boundary: 1..15 from right, then a held 16th push.
        for (int k = 1; k <= DEPTH; k++) begin
            in_ready[1] = 1'b1;
            in_data[1]  = WIDTH'(k);
            tick();
            check($sformatf("full_ack%0d", k), int'(in_ack[1]), 1);
            in_ready[1] = 1'b0;
            tick();
        end
        check("full_count", int'(count), DEPTH);
        in_ready[1] = 1'b1;
        in_data[1]  = WIDTH'(16);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("full_noack%0d", k), int'(in_ack[1]), 0);
            check($sformatf("full_hold%0d", k), int'(count), DEPTH);
        end
        out_req[3] = 1'b1;
        sb_expect(3, 15);
        tick();
        check("full_swap_ack", int'(in_ack[1]), 1);
        check("full_swap_ready", int'(out_ready[3]), 1);
        check("full_swap_count", int'(count), DEPTH);
        in_ready[1] = 1'b0;
        out_req[3]  = 1'b0;
        tick();
        // Drain: 16 replaced 15 on top, then 14 down to 1.
        for (int k = 0; k < DEPTH; k++) begin
            out_req[2] = 1'b1;
            sb_expect(2, (k == 0) ? 16 : DEPTH - k);
            tick();
            out_req[2] = 1'b0;
            tick();
        end
        check("drain_count", int'(count), 0);

        // Empty pop: right waits until a word arrives from up.
        out_req[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("empty_noready%0d", k), int'(out_ready[1]), 0);
        end
        in_ready[2] = 1'b1;
        in_data[2]  = WIDTH'(42);
        sb_expect(1, 42);
        tick();
        check("empty_push_ack", int'(in_ack[2]), 1);
        check("empty_push_noready", int'(out_ready[1]), 0);
        check("empty_push_count", int'(count), 1);
        in_ready[2] = 1'b0;
        tick();
        check("empty_served", int'(out_ready[1]), 1);
        check("empty_served_count", int'(count), 0);
        out_req[1] = 1'b0;
        tick();
        check("empty_after_count", int'(count), 0);

        // Reset mid-operation with count=6, left_in_ready high, pulses live.
        for (int k = 0; k < 6; k++) begin
            in_ready[0] = 1'b1;
            in_data[0]  = WIDTH'(100 + k);
            tick();
            in_ready[0] = 1'b0;
            tick();
        end
        check("pre_rst_count", int'(count), 6);
        in_ready[0] = 1'b1;
        in_data[0]  = WIDTH'(77);
        out_req[2]  = 1'b1;
        tick();
        check("pre_rst_ack", int'(in_ack[0]), 1);
        check("pre_rst_ready", int'(out_ready[2]), 1);
        check("pre_rst_data", sx(out_data[2]), 105);
        check("pre_rst_count6", int'(count), 6);
        reset = 1'b0;
        #1;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_ack", int'(in_ack), 0);
        check("mid_rst_ready", int'(out_ready), 0);
        for (int i = 0; i < 4; i++) check($sformatf("mid_rst_data%0d", i), sx(out_data[i]), 0);
        tick();
        check("held_rst_count", int'(count), 0);
        check("held_rst_ack", int'(in_ack), 0);
        in_ready[0] = 1'b0;
        out_req[2]  = 1'b0;
        reset = 1'b1;
        out_req[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("post_rst_noready%0d", k), int'(out_ready[0]), 0);
            check($sformatf("post_rst_count%0d", k), int'(count), 0);
        end
        in_ready[3] = 1'b1;
        in_data[3]  = WIDTH'(55);
        sb_expect(0, 55);
        tick();
        check("post_rst_push_ack", int'(in_ack[3]), 1);
        check("post_rst_push_count", int'(count), 1);
        in_ready[3] = 1'b0;
        tick();
        check("post_rst_pop_ready", int'(out_ready[0]), 1);
        check("post_rst_pop_count", int'(count), 0);
        out_req[0] = 1'b0;
        tick();
        tick();

        check("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
